monolith_sponge: RTL
====================

Name: monolith_sponge

Overview:
- Sponge front-end that sits directly upstream of the Monolith permutation engine and drives its state and restart.
- Accepts a stream of message field elements over a valid/ready handshake and packs them into the rate portion of the state (overwrite mode).
- Applies padding, launches one permutation per block and returns the digest on a valid/ready output.
- The permutation engine is restarted through its active-high reset for every block.

Parameters:
WORD_WIDTH, 31, field element width
STATE_SIZE, 16, permutation state words
RATE, 8, rate words per block (1 <= RATE < STATE_SIZE)
DIGEST_SIZE, 8, output words (<= RATE)
MODULUS, 2^31-1, field prime used for input reduction

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
msg_data  in  WORD_WIDTH  message element
msg_valid  in  1  msg_data valid
msg_last  in  1  final element of message, qualified by msg_valid
msg_ready  out  1  block accepts an element
perm_reset  out  1  active-high restart of permutation engine
perm_state_in  out  STATE_SIZE x WORD_WIDTH  state presented to permutation
perm_state_out  in  STATE_SIZE x WORD_WIDTH  permutation result
perm_valid  in  1  permutation result valid (level, held until perm_reset)
digest  out  DIGEST_SIZE x WORD_WIDTH  state words 0..DIGEST_SIZE-1, zero when digest_valid=0
digest_valid  out  1  digest available
digest_ready  in  1  consumer accepts digest

Behaviour:
- Reset (reset=0 at posedge): FSM=ABSORB, state regs all 0, pos=0, pad_pending=0, final=0.
  - Outputs during/after reset: msg_ready=0 while reset low, perm_reset=1, digest_valid=0, digest=0.
- perm_state_in = state regs, combinationally; stable for the whole permutation.
- perm_reset = 1 in every state except WAIT.
- Input reduction: msg_data >= MODULUS is stored as msg_data-MODULUS; e.g. 0x7FFFFFFF -> 0.
- FSM:
  - ABSORB: msg_ready=1. On msg_valid&&msg_ready: state[pos] <= reduce(msg_data).
    - not last, pos<RATE-1: pos++.
    - not last, pos==RATE-1: -> LAUNCH.
    - last, pos<RATE-1: state[pos+1] <= 1; state[pos+2..RATE-1] <= 0; final=1; -> LAUNCH.
    - last, pos==RATE-1: pad_pending=1; -> LAUNCH.
    - Capacity words (RATE..STATE_SIZE-1) are never written from input.
  - LAUNCH: exactly one cycle, perm_reset=1, msg_ready=0; -> WAIT.
  - WAIT: perm_reset=0, msg_ready=0. On perm_valid: state <= perm_state_out, then:
    - pad_pending: in the same cycle overwrite rate with {1,0,..,0}; pad_pending=0; final=1; -> LAUNCH.
    - final: -> DONE.
    - otherwise: pos=0; -> ABSORB.
  - DONE: digest_valid=1, msg_ready=0. On digest_ready:
    - state regs <= 0, pos=0, final=0; -> ABSORB.
    - msg_ready rises the next cycle.
- Latency: a block triggers LAUNCH the cycle after its final element handshake.
  - Digest appears 1 cycle after perm_valid is sampled for the final block.
  - Permutation latency is whatever the engine takes; the block imposes no timeout.
- Zero-length messages are impossible: msg_last always accompanies an element.
- msg_last while msg_valid=0 is ignored.
- Back-to-back messages: state starts from all-zero for every message.
- perm_valid sampled outside WAIT is ignored.
- reset low mid-operation: abort immediately, all registers to reset values, in-flight permutation discarded (perm_reset=1).

Test Plan:
- Stub perm (out[i]=(in[i]+i+1) mod p, latency 10). Send 3 elements 5,6,7 (last on 7) -> perm_state_in = {5,6,7,1,0,0,0,0,0...0}; digest = {6,8,10,5,5,6,7,8}; exactly one LAUNCH.
- Send 8 elements 1..8, last on 8 -> two permutations; second perm_state_in rate = {1,0,0,0,0,0,0,0} with capacity = first result words 8..15 = {9..16}.
- Send 10 elements (two blocks, second partial) -> msg_ready low during the first permutation; the 9th element is accepted only after WAIT->ABSORB; the second block is padded at rate position 2.
- Send msg_data=0x7FFFFFFF and 0x7FFFFFFE -> stored 0 and 0x7FFFFFFE.
- Hold digest_ready=0 for 20 cycles in DONE -> digest_valid and digest stable, msg_ready=0; assert digest_ready -> next message perm_state_in capacity words all 0.
- Assert reset=0 during WAIT -> next cycle digest_valid=0, perm_reset=1, state=0; a new message completes correctly.

Source files
------------

// File: rtl/monolith_sponge.sv
// Sponge front-end for the Monolith permutation: packs message elements into the rate, pads, and launches one permutation per block.
// Latency: LAUNCH one cycle after a block's final element handshake; digest one cycle after perm_valid for the final block.
// Backpressure: msg_ready only in ABSORB; the digest is held in DONE until digest_ready.
// Ports: clk/reset (sync, active-low); msg_* input stream; perm_* drive and observe the permutation engine;
//        digest/digest_valid/digest_ready carry the result out.
module monolith_sponge #(
    parameter int                    WORD_WIDTH  = 31,
    parameter int                    STATE_SIZE  = 16,
    parameter int                    RATE        = 8,
    parameter int                    DIGEST_SIZE = 8,
    parameter logic [WORD_WIDTH-1:0] MODULUS     = 31'h7FFF_FFFF
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [WORD_WIDTH-1:0]                  msg_data,
    input  logic                                   msg_valid,
    input  logic                                   msg_last,
    output logic                                   msg_ready,
    output logic                                   perm_reset,
    output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  perm_state_in,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  perm_state_out,
    input  logic                                   perm_valid,
    output logic [DIGEST_SIZE-1:0][WORD_WIDTH-1:0] digest,
    output logic                                   digest_valid,
    input  logic                                   digest_ready
);

    localparam int POS_W = (RATE > 1) ? $clog2(RATE) : 1;

    typedef enum logic [1:0] {
        ST_ABSORB = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } fsm_t;

    fsm_t                                  fsm_q, fsm_d;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_q, state_d;
    logic [POS_W-1:0]                      pos_q, pos_d;
    logic                                  pad_pending_q, pad_pending_d;
    logic                                  final_q, final_d;
    logic [WORD_WIDTH-1:0]                 reduced;
    logic                                  pos_at_end;

    // A single conditional subtract suffices: inputs are below 2*MODULUS.
    assign reduced    = (msg_data >= MODULUS) ? (msg_data - MODULUS) : msg_data;
    assign pos_at_end = (pos_q == POS_W'(RATE - 1));

    // Outputs are gated by reset so they take their idle values while reset is held.
    assign msg_ready     = reset && (fsm_q == ST_ABSORB);
    assign perm_reset    = !reset || (fsm_q != ST_WAIT);
    assign digest_valid  = reset && (fsm_q == ST_DONE);
    assign perm_state_in = state_q;

    always_comb begin
        for (int i = 0; i < DIGEST_SIZE; i++) begin
            digest[i] = digest_valid ? state_q[i] : '0;
        end
    end

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        pos_d         = pos_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;

        case (fsm_q)
            ST_ABSORB: begin
                if (msg_valid) begin
                    // Overwrite mode: the element lands at pos; on the last element the
                    // 1-padding follows it and the rest of the rate is cleared.
                    for (int i = 0; i < RATE; i++) begin
                        if (i == int'(pos_q)) begin
                            state_d[i] = reduced;
                        end else if (msg_last && (i == int'(pos_q) + 1)) begin
                            state_d[i] = WORD_WIDTH'(1);
                        end else if (msg_last && (i > int'(pos_q) + 1)) begin
                            state_d[i] = '0;
                        end
                    end
                    if (msg_last) begin
                        // A full final block leaves no room for the pad word: it
                        // goes into an extra block after this permutation.
                        if (pos_at_end) begin
                            pad_pending_d = 1'b1;
                        end else begin
                            final_d = 1'b1;
                        end
                        fsm_d = ST_LAUNCH;
                    end else if (pos_at_end) begin
                        fsm_d = ST_LAUNCH;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end

            ST_LAUNCH: begin
                fsm_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (perm_valid) begin
                    state_d = perm_state_out;
                    if (pad_pending_q) begin
                        for (int i = 0; i < RATE; i++) begin
                            state_d[i] = (i == 0) ? WORD_WIDTH'(1) : '0;
                        end
                        pad_pending_d = 1'b0;
                        final_d       = 1'b1;
                        fsm_d         = ST_LAUNCH;
                    end else if (final_q) begin
                        fsm_d = ST_DONE;
                    end else begin
                        pos_d = '0;
                        fsm_d = ST_ABSORB;
                    end
                end
            end

            ST_DONE: begin
                if (digest_ready) begin
                    // Next message starts from an all-zero state.
                    state_d = '0;
                    pos_d   = '0;
                    final_d = 1'b0;
                    fsm_d   = ST_ABSORB;
                end
            end

            default: begin
                fsm_d = ST_ABSORB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q         <= ST_ABSORB;
            state_q       <= '0;
            pos_q         <= '0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            pos_q         <= pos_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
        end
    end

endmodule
